// File: rtl/lcd_pkg.sv
// Shared HD44780 definitions: opcodes, address-counter type, responder states
// and the address-counter stepping rule.
package lcd_pkg;

    // Instruction opcodes; the leading one bit selects the instruction class
    localparam logic [7:0] CMD_CLEAR   = 8'h01;
    localparam logic [7:0] CMD_HOME    = 8'h02;
    localparam logic [7:0] CMD_ENTRY   = 8'h04;
    localparam logic [7:0] CMD_DISPCTL = 8'h08;
    localparam logic [7:0] CMD_SHIFT   = 8'h10;
    localparam logic [7:0] CMD_FUNC    = 8'h20;
    localparam logic [7:0] CMD_CGRAM   = 8'h40;
    localparam logic [7:0] CMD_DDRAM   = 8'h80;

    localparam logic [7:0] SPACE_CHAR  = 8'h20;

    typedef logic [6:0] ac_t;

    // Visible DDRAM windows for one-line and two-line modes
    localparam ac_t ONE_LINE_END = 7'h4F;
    localparam ac_t LINE1_END    = 7'h27;
    localparam ac_t LINE2_START  = 7'h40;
    localparam ac_t LINE2_END    = 7'h67;

    typedef enum logic [1:0] {
        ST_CLEAR_FILL,
        ST_BUSY,
        ST_IDLE,
        ST_EXEC
    } resp_state_t;

    // Next address-counter value; out-of-window addresses wrap to 0 going up
    // and to the last visible address going down.
    function automatic ac_t ac_step(input ac_t ac, input logic inc, input logic two_line);
        ac_t r;
        logic out_of_range;
        if (two_line) begin
            out_of_range = (ac > LINE2_END) || ((ac > LINE1_END) && (ac < LINE2_START));
            if (inc) begin
                if (ac == LINE1_END)
                    r = LINE2_START;
                else if (out_of_range || (ac == LINE2_END))
                    r = 7'h00;
                else
                    r = ac + 7'd1;
            end else begin
                if (ac == LINE2_START)
                    r = LINE1_END;
                else if (out_of_range || (ac == 7'h00))
                    r = LINE2_END;
                else
                    r = ac - 7'd1;
            end
        end else begin
            if (inc) begin
                if (ac >= ONE_LINE_END)
                    r = 7'h00;
                else
                    r = ac + 7'd1;
            end else begin
                if ((ac == 7'h00) || (ac > ONE_LINE_END))
                    r = ONE_LINE_END;
                else
                    r = ac - 7'd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 128x8 character store: one write port, a read port for the bus side and an
// independent read port for the renderer, both with registered output.
module lcd_ddram (
    input  logic       clk,
    input  logic       we_i,
    input  logic [6:0] waddr_i,
    input  logic [7:0] wdata_i,
    input  logic [6:0] bus_addr_i,
    output logic [7:0] bus_data_o,
    input  logic [6:0] ren_addr_i,
    output logic [7:0] ren_data_o
);

    logic [7:0] mem [0:127];
    logic [7:0] bus_data_q;
    logic [7:0] ren_data_q;

    // Write port plus two registered read ports (maps onto block RAM)
    always_ff @(posedge clk) begin
        if (we_i)
            mem[waddr_i] <= wdata_i;
        bus_data_q <= mem[bus_addr_i];
        ren_data_q <= mem[ren_addr_i];
    end

    assign bus_data_o = bus_data_q;
    assign ren_data_o = ren_data_q;

endmodule

// File: rtl/hd44780_responder.sv
// LCD-module side of the HD44780 8-bit bus: samples the pins, executes
// instructions, keeps DDRAM/AC/BF/display flags and answers bus reads.
module hd44780_responder
    import lcd_pkg::*;
#(
    parameter int BUSY_SHORT = 1850,
    parameter int BUSY_LONG  = 76000,
    parameter int BUSY_POR   = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RS,
    input  logic       RW,
    input  logic       E,
    input  logic [7:0] db_in,
    output logic [7:0] db_out,
    output logic       db_oe,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_char,
    output logic       busy,
    output logic [6:0] ac,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       two_line,
    output logic       busy_write_err
);

    // Pin synchronizers and edge detect
    logic       rs_s1_q, rs_s2_q, rw_s1_q, rw_s2_q, e_s1_q, e_s2_q, e_prev_q;
    logic [7:0] db_s1_q, db_s2_q;
    logic       e_fall;

    // Byte captured on the strobe
    logic       rs_lat_q;
    logic [7:0] db_lat_q;

    // Controller state
    resp_state_t state_q;
    logic        busy_q;
    logic [31:0] cnt_q;
    logic [6:0]  fill_q;
    logic        por_q;
    ac_t         ac_q;
    logic        id_q, s_q, dl_q;
    logic        disp_on_q, cursor_on_q, blink_on_q, two_line_q, err_q;

    // RAM interface
    logic       ram_we;
    logic [6:0] ram_waddr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_bus_data;
    logic [7:0] db_out_q;

    // Two-flop synchronizers on every pin, plus previous synced E
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs_s1_q  <= 1'b0;
            rs_s2_q  <= 1'b0;
            rw_s1_q  <= 1'b0;
            rw_s2_q  <= 1'b0;
            e_s1_q   <= 1'b0;
            e_s2_q   <= 1'b0;
            e_prev_q <= 1'b0;
            db_s1_q  <= 8'h00;
            db_s2_q  <= 8'h00;
        end else begin
            rs_s1_q  <= RS;
            rs_s2_q  <= rs_s1_q;
            rw_s1_q  <= RW;
            rw_s2_q  <= rw_s1_q;
            e_s1_q   <= E;
            e_s2_q   <= e_s1_q;
            e_prev_q <= e_s2_q;
            db_s1_q  <= db_in;
            db_s2_q  <= db_s1_q;
        end
    end

    assign e_fall = e_prev_q & ~e_s2_q;

    // Capture RS and data on the strobe's falling edge for EXEC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs_lat_q <= 1'b0;
            db_lat_q <= 8'h00;
        end else if (e_fall) begin
            rs_lat_q <= rs_s2_q;
            db_lat_q <= db_s2_q;
        end
    end

    // Main controller: fill, busy timing, instruction execution, read side effects
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_CLEAR_FILL;
            busy_q      <= 1'b1;
            cnt_q       <= 32'd0;
            fill_q      <= 7'd0;
            por_q       <= 1'b1;
            ac_q        <= 7'd0;
            id_q        <= 1'b1;
            s_q         <= 1'b0;
            dl_q        <= 1'b1;
            disp_on_q   <= 1'b0;
            cursor_on_q <= 1'b0;
            blink_on_q  <= 1'b0;
            two_line_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // A write strobe while busy is dropped but remembered
            if (e_fall && !rw_s2_q && (state_q != ST_IDLE))
                err_q <= 1'b1;

            // Data reads advance AC; EXEC owns AC on its single cycle
            if (e_fall && rw_s2_q && rs_s2_q && (state_q != ST_EXEC))
                ac_q <= ac_step(ac_q, id_q, two_line_q);

            case (state_q)
                ST_CLEAR_FILL: begin
                    fill_q <= fill_q + 7'd1;
                    if (fill_q == 7'h7F) begin
                        cnt_q   <= por_q ? 32'(BUSY_POR) : 32'(BUSY_LONG);
                        por_q   <= 1'b0;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cnt_q == 32'd0) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 32'd1;
                    end
                end
                ST_IDLE: begin
                    if (e_fall && !rw_s2_q) begin
                        state_q <= ST_EXEC;
                        busy_q  <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    state_q <= ST_BUSY;
                    cnt_q   <= 32'(BUSY_SHORT);
                    if (rs_lat_q) begin
                        ac_q <= ac_step(ac_q, id_q, two_line_q);
                    end else if ((db_lat_q & CMD_DDRAM) != 8'h00) begin
                        ac_q <= db_lat_q[6:0];
                    end else if ((db_lat_q & CMD_CGRAM) != 8'h00) begin
                        // CGRAM address accepted, CGRAM itself not modelled
                    end else if ((db_lat_q & CMD_FUNC) != 8'h00) begin
                        dl_q       <= db_lat_q[4];
                        two_line_q <= db_lat_q[3];
                    end else if ((db_lat_q & CMD_SHIFT) != 8'h00) begin
                        if (!db_lat_q[3])
                            ac_q <= ac_step(ac_q, db_lat_q[2], two_line_q);
                    end else if ((db_lat_q & CMD_DISPCTL) != 8'h00) begin
                        disp_on_q   <= db_lat_q[2];
                        cursor_on_q <= db_lat_q[1];
                        blink_on_q  <= db_lat_q[0];
                    end else if ((db_lat_q & CMD_ENTRY) != 8'h00) begin
                        id_q <= db_lat_q[1];
                        s_q  <= db_lat_q[0];
                    end else if ((db_lat_q & CMD_HOME) != 8'h00) begin
                        ac_q  <= 7'd0;
                        cnt_q <= 32'(BUSY_LONG);
                    end else if (db_lat_q == CMD_CLEAR) begin
                        ac_q    <= 7'd0;
                        id_q    <= 1'b1;
                        fill_q  <= 7'd0;
                        state_q <= ST_CLEAR_FILL;
                    end
                end
                default: state_q <= ST_CLEAR_FILL;
            endcase
        end
    end

    // RAM write port: the clear fill has priority, else an EXEC data write
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = ac_q;
        ram_wdata = db_lat_q;
        if (state_q == ST_CLEAR_FILL) begin
            ram_we    = 1'b1;
            ram_waddr = fill_q;
            ram_wdata = SPACE_CHAR;
        end else if ((state_q == ST_EXEC) && rs_lat_q) begin
            ram_we = 1'b1;
        end
    end

    lcd_ddram u_ddram (
        .clk        (clk),
        .we_i       (ram_we),
        .waddr_i    (ram_waddr),
        .wdata_i    (ram_wdata),
        .bus_addr_i (ac_q),
        .bus_data_o (ram_bus_data),
        .ren_addr_i (rd_addr),
        .ren_data_o (rd_char)
    );

    // Read data register: status word or DDRAM[AC] depending on synced RS
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            db_out_q <= 8'h00;
        else
            db_out_q <= rs_s2_q ? ram_bus_data : {busy_q, ac_q};
    end

    assign db_out         = db_out_q;
    assign db_oe          = e_s2_q & rw_s2_q;
    assign busy           = busy_q;
    assign ac             = ac_q;
    assign disp_on        = disp_on_q;
    assign cursor_on      = cursor_on_q;
    assign blink_on       = blink_on_q;
    assign two_line       = two_line_q;
    assign busy_write_err = err_q;

    // Interface length and display shift are stored but have no effect here
    logic unused_flags;
    assign unused_flags = dl_q ^ s_q;

endmodule

// File: tb/tb_hd44780_responder.sv
// Directed bench for hd44780_responder with an expected-value scoreboard.
module tb_hd44780_responder;

    localparam int P_SHORT = 200;
    localparam int P_LONG  = 400;
    localparam int P_POR   = 500;

    logic       clk = 1'b0;
    logic       rst;
    logic       RS, RW, E;
    logic [7:0] db_in;
    logic [7:0] db_out;
    logic       db_oe;
    logic [6:0] rd_addr;
    logic [7:0] rd_char;
    logic       busy;
    logic [6:0] ac;
    logic       disp_on, cursor_on, blink_on, two_line, busy_write_err;

    int unsigned cyc = 0;
    int n_pass  = 0;
    int n_total = 0;

    string       tag_q[$];
    logic [31:0] exp_q[$];

    hd44780_responder #(
        .BUSY_SHORT (P_SHORT),
        .BUSY_LONG  (P_LONG),
        .BUSY_POR   (P_POR)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .RS             (RS),
        .RW             (RW),
        .E              (E),
        .db_in          (db_in),
        .db_out         (db_out),
        .db_oe          (db_oe),
        .rd_addr        (rd_addr),
        .rd_char        (rd_char),
        .busy           (busy),
        .ac             (ac),
        .disp_on        (disp_on),
        .cursor_on      (cursor_on),
        .blink_on       (blink_on),
        .two_line       (two_line),
        .busy_write_err (busy_write_err)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic sb_expect(input string tag, input logic [31:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        n_total++;
        if (exp_q.size() == 0) begin
            $error("FAIL scoreboard_empty: got %0h with no expected value queued", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) begin
                n_pass++;
                $display("check %s: got %0h expected %0h", t, obs, e);
            end else begin
                $error("FAIL %s: got %0h expected %0h", t, obs, e);
            end
        end
    endtask

    task automatic bus_write(input logic rs, input logic [7:0] d);
        @(negedge clk);
        RS = rs; RW = 1'b0; db_in = d;
        repeat (2) @(negedge clk);
        E = 1'b1;
        repeat (4) @(negedge clk);
        E = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic bus_read(input logic rs, output logic [7:0] d, output logic oe,
                            output logic oe_after);
        @(negedge clk);
        RS = rs; RW = 1'b1;
        repeat (2) @(negedge clk);
        E = 1'b1;
        repeat (6) @(negedge clk);
        d  = db_out;
        oe = db_oe;
        E  = 1'b0;
        repeat (4) @(negedge clk);
        oe_after = db_oe;
        RW = 1'b0;
    endtask

    task automatic wait_idle(input int bound, output int n);
        n = 0;
        while ((busy !== 1'b0) && (n < bound)) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Instruction/data write, then BF raised and held for the short busy time
    task automatic write_wait(input logic rs, input logic [7:0] d, input string tag);
        int n;
        bus_write(rs, d);
        sb_expect({tag, "_bf"}, 32'd1);
        sb_check({31'd0, busy});
        wait_idle(5000, n);
        sb_expect({tag, "_busy_len"}, 32'd1);
        sb_check({31'd0, (n >= P_SHORT - 10) && (n <= P_SHORT + 10)});
    endtask

    task automatic sweep_space(input string tag);
        for (int a = 0; a < 128; a++) begin
            rd_addr = 7'(a);
            @(negedge clk);
            sb_expect($sformatf("%s_%0h", tag, a), 32'h20);
            sb_check({24'd0, rd_char});
        end
    endtask

    task automatic check_char(input logic [6:0] a, input logic [7:0] e, input string tag);
        rd_addr = a;
        sb_expect(tag, {24'd0, e});
        @(negedge clk);
        sb_check({24'd0, rd_char});
    endtask

    initial begin
        logic [7:0]  d;
        logic        oe, oe_after;
        int          n;
        int unsigned t0;

        rst = 1'b1; RS = 1'b0; RW = 1'b0; E = 1'b0; db_in = 8'h00; rd_addr = 7'd0;
        repeat (5) @(negedge clk);

        // Reset state
        sb_expect("rst_db_oe", 32'd0);      sb_check({31'd0, db_oe});
        sb_expect("rst_db_out", 32'd0);     sb_check({24'd0, db_out});
        sb_expect("rst_busy", 32'd1);       sb_check({31'd0, busy});
        sb_expect("rst_ac", 32'd0);         sb_check({25'd0, ac});
        sb_expect("rst_flags", 32'd0);
        sb_check({28'd0, disp_on, cursor_on, blink_on, two_line});
        sb_expect("rst_err", 32'd0);        sb_check({31'd0, busy_write_err});

        rst = 1'b0;
        t0 = cyc;

        // Status during power-on fill/busy
        bus_read(1'b0, d, oe, oe_after);
        sb_expect("por_status", 32'h80);    sb_check({24'd0, d});
        sb_expect("por_read_oe", 32'd1);    sb_check({31'd0, oe});
        sb_expect("por_read_oe_drop", 32'd0); sb_check({31'd0, oe_after});

        wait_idle(5000, n);
        sb_expect("por_len", 32'd1);
        sb_check({31'd0, ((cyc - t0) >= 128 + P_POR - 3) && ((cyc - t0) <= 128 + P_POR + 3)});
        bus_read(1'b0, d, oe, oe_after);
        sb_expect("ready_status", 32'h00);  sb_check({24'd0, d});
        sweep_space("por_fill");

        // Initialisation sequence
        write_wait(1'b0, 8'h38, "func_set");
        sb_expect("two_line", 32'd1);       sb_check({31'd0, two_line});
        write_wait(1'b0, 8'h0C, "disp_ctl");
        sb_expect("disp_flags", 32'b100);   sb_check({29'd0, disp_on, cursor_on, blink_on});
        write_wait(1'b0, 8'h06, "entry");

        // Data across the line-1/line-2 boundary
        write_wait(1'b0, 8'hA6, "set_ac26");
        sb_expect("ac_26", 32'h26);         sb_check({25'd0, ac});
        write_wait(1'b1, 8'h41, "data41");
        write_wait(1'b1, 8'h42, "data42");
        sb_expect("ac_wrap_40", 32'h40);    sb_check({25'd0, ac});

        // Write while busy is dropped and flagged
        bus_write(1'b1, 8'h43);
        sb_expect("err_before", 32'd0);     sb_check({31'd0, busy_write_err});
        repeat (90) @(negedge clk);
        bus_write(1'b1, 8'h50);
        sb_expect("err_set", 32'd1);        sb_check({31'd0, busy_write_err});
        sb_expect("ac_after_drop", 32'h41); sb_check({25'd0, ac});
        wait_idle(5000, n);
        check_char(7'h26, 8'h41, "ram_26");
        check_char(7'h27, 8'h42, "ram_27");
        check_char(7'h40, 8'h43, "ram_40");
        check_char(7'h41, 8'h20, "ram_41_untouched");
        bus_read(1'b0, d, oe, oe_after);
        sb_expect("status_41", 32'h41);     sb_check({24'd0, d});

        // Clear display
        bus_write(1'b0, 8'h01);
        t0 = cyc;
        bus_read(1'b0, d, oe, oe_after);
        sb_expect("clear_status", 32'h80);  sb_check({24'd0, d});
        wait_idle(5000, n);
        sb_expect("clear_len", 32'd1);
        sb_check({31'd0, ((cyc - t0) >= 128 + P_LONG - 10) && ((cyc - t0) <= 128 + P_LONG + 10)});
        sb_expect("clear_ac", 32'd0);       sb_check({25'd0, ac});
        sweep_space("clear_fill");

        // Data read with decrementing entry mode
        write_wait(1'b0, 8'h85, "set_ac05");
        write_wait(1'b1, 8'h5A, "data5a");
        sb_expect("ac_06", 32'h06);         sb_check({25'd0, ac});
        write_wait(1'b0, 8'h85, "set_ac05b");
        write_wait(1'b0, 8'h04, "entry_dec");
        bus_read(1'b1, d, oe, oe_after);
        sb_expect("data_read", 32'h5A);     sb_check({24'd0, d});
        sb_expect("data_read_oe", 32'd1);   sb_check({31'd0, oe});
        sb_expect("data_read_oe_drop", 32'd0); sb_check({31'd0, oe_after});
        sb_expect("ac_after_read", 32'h04); sb_check({25'd0, ac});

        // Two-line boundaries in both directions
        write_wait(1'b0, 8'hC0, "set_ac40");
        write_wait(1'b1, 8'h33, "data33");
        sb_expect("ac_dec_40_27", 32'h27);  sb_check({25'd0, ac});
        check_char(7'h40, 8'h33, "ram_40_b");
        write_wait(1'b0, 8'h06, "entry_inc");
        write_wait(1'b0, 8'hE7, "set_ac67");
        write_wait(1'b1, 8'h34, "data34");
        sb_expect("ac_inc_67_00", 32'h00);  sb_check({25'd0, ac});
        check_char(7'h67, 8'h34, "ram_67");

        // Status read has no side effect
        bus_read(1'b0, d, oe, oe_after);
        sb_expect("status_00", 32'h00);     sb_check({24'd0, d});
        sb_expect("ac_unchanged", 32'h00);  sb_check({25'd0, ac});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
